ps2_keyboard: RTL and testbench
===============================

Name: ps2_keyboard

Overview:
PS/2 keyboard receiver plus an 8-byte scan-code FIFO, exposed to the AVR core as two I/O ports.
- Direction is the reverse of the existing bank/cursor registers: hardware produces the bytes and the CPU consumes them.
- Sits beside the memory router on the CPU address/data bus and drives PS2_CLK/PS2_DAT as inputs only.
- Gives the CPU polled keyboard input for the text-mode console.

Parameters:
PORT_DATA, 16'h30, I/O address of the data port: read = FIFO head; write of any value = pop.
PORT_STAT, 16'h31, I/O address of the status port: read = status byte; write = write-1-to-clear of sticky error bits.
DEPTH_LOG2, 3, FIFO depth is 2**DEPTH_LOG2 bytes.
FILTER, 8, number of consecutive equal samples of synchronized ps2_clk before its level is accepted.
TIMEOUT, 25000, idle clock cycles mid-frame before the frame is aborted (1 ms at 25 MHz).

Ports:
clock  in  1  system clock (same clock as clock_cpu); all state is updated on the rising edge.
reset  in  1  asynchronous, active-high reset.
ps2_clk  in  1  raw PS/2 clock line (asynchronous).
ps2_dat  in  1  raw PS/2 data line (asynchronous).
address  in  16  CPU data address.
wren  in  1  CPU write enable.
data_w  in  8  CPU write data.
data_r  out  8  read data; valid only when hit=1, otherwise 8'h00.
hit  out  1  combinational; 1 when address==PORT_DATA or address==PORT_STAT.
irq  out  1  registered; 1 when the FIFO is not empty.

Behaviour:
Reset
- Async reset clears FIFO pointers, count, sticky bits, the FSM (to IDLE), the filter and the timeout counter.
- Filtered ps2_clk resets to 1.
- Outputs after reset: irq=0; data_r=0 unless addressed.

Input conditioning and sampling
- Both lines pass through 2-flop synchronizers.
- ps2_clk goes through the FILTER-sample stability filter.
- A sample event is a 1->0 transition of the filtered clock; ps2_dat (synchronized) is sampled on that cycle.

Receive FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE
- IDLE: a sample event with dat=0 (start bit) -> DATA, bit count=0. A sample with dat=1 is ignored.
- DATA: shift data in LSB first. After the 8th bit -> PARITY.
- PARITY: capture the parity bit -> STOP.
- STOP, on its sample event:
  - stop=1 and odd parity correct (data bits XOR parity bit = 1): push the byte.
  - parity wrong: drop the byte and set perr.
  - stop=0: drop the byte and set ferr.
  - Return to IDLE in every case.
- Timeout: in any state other than IDLE, TIMEOUT cycles with no sample event force IDLE and set ferr. The timeout counter clears on every sample event.

FIFO
- Push happens on the cycle after the stop-bit sample event, i.e. 1 cycle latency from that edge to irq/status visible.
- Pop happens on the clock edge where wren=1 and address==PORT_DATA.
- Pop when empty: ignored, no side effects.
- Push when full with no simultaneous pop: byte dropped, ovf set.
- Simultaneous push and pop: both take effect and count is unchanged; this holds even when full, so no ovf is raised.
- Pointers wrap modulo depth. Count is DEPTH_LOG2+1 bits.

Read path (combinational from address)
- PORT_DATA: the head byte, or 8'h00 when empty.
- PORT_STAT bits:
  - [0] not empty
  - [1] full
  - [2] perr
  - [3] ferr
  - [4] ovf
  - [7:5] = 0

Status write
- wren=1 at PORT_STAT clears each sticky bit whose data_w bit is 1 (bits 2..4).
- If a set and a clear of the same bit occur in the same cycle, set wins.

Misc
- No host-to-device transmission; ps2_clk/ps2_dat are never driven.
- A reset pulse mid-frame discards the partial byte with no error bits set.

Decomposition:
- Shared package ps2_pkg holds:
  - PORT_DATA/PORT_STAT default addresses.
  - Status bit index constants ST_NE, ST_FULL, ST_PERR, ST_FERR, ST_OVF.
  - FSM state encoding (IDLE, DATA, PARITY, STOP).
- One sub-module, ps2_rx_frame: synchronizers, filter, FSM and timeout. Outputs are a 1-cycle byte_valid strobe, the byte, perr_pulse and ferr_pulse.
- The FIFO and port decode stay in ps2_keyboard.

Test Plan:
1. Frame for 8'h1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at a 40 us clock period -> status reads 8'h01, PORT_DATA reads 8'h1C, irq=1; after a write to PORT_DATA, status reads 8'h00 and irq=0.
2. 8'hF0 sent with parity bit 0 (wrong) -> FIFO stays empty, status reads 8'h04; write 8'h04 to PORT_STAT -> status reads 8'h00.
3. Send 9 valid bytes 8'h01..8'h09 without popping -> status reads 8'h13 (ne, full, ovf); 8 pops return 8'h01..8'h08 in order, after which status reads 8'h10.
4. Start bit plus 3 data bits, then the line stays idle for 25000 cycles -> status reads 8'h08, FSM back in IDLE; a following valid 8'h5A is received correctly.
5. FIFO full and a pop issued on the exact push cycle -> count stays 8, ovf=0, new byte at the tail.
6. 1-cycle glitches on ps2_clk mid-frame, plus assertion of reset mid-frame -> glitches produce no sample events; after reset, status reads 8'h00 and FIFO is empty.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants for the PS/2 keyboard receiver.
//   - default I/O addresses of the data and status ports
//   - status byte bit positions
//   - receive FSM state encoding
//   - odd-parity helper used by the frame receiver
`timescale 1ns/1ps
package ps2_pkg;

    localparam logic [15:0] PORT_DATA_DEF = 16'h0030;
    localparam logic [15:0] PORT_STAT_DEF = 16'h0031;

    localparam int unsigned ST_NE   = 0;
    localparam int unsigned ST_FULL = 1;
    localparam int unsigned ST_PERR = 2;
    localparam int unsigned ST_FERR = 3;
    localparam int unsigned ST_OVF  = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    // Odd parity: data bits together with the parity bit must XOR to 1.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: PS/2 device-to-host frame receiver.
//   clk_i, rst_i    system clock, async active-high reset
//   ps2_clk_i       raw PS/2 clock line
//   ps2_dat_i       raw PS/2 data line
//   byte_valid_o    1-cycle strobe, byte_o holds a correctly framed byte
//   byte_o          received byte
//   perr_pulse_o    1-cycle strobe, frame dropped on parity error
//   ferr_pulse_o    1-cycle strobe, frame dropped on bad stop bit or timeout
`timescale 1ns/1ps
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 25000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       perr_pulse_o,
    output logic       ferr_pulse_o
);

    localparam int unsigned FCW = $clog2(FILTER) + 1;
    localparam int unsigned TCW = $clog2(TIMEOUT) + 1;

    logic [1:0]     clk_sync_q;
    logic [1:0]     dat_sync_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    logic [1:0]     state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [TCW-1:0] to_cnt_q, to_cnt_d;
    logic           valid_q, valid_d;
    logic           perr_q, perr_d;
    logic           ferr_q, ferr_d;
    logic           clk_s, dat_s;
    logic           sample;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];

    // Idle PS/2 lines are high, so synchronizers and filter reset to 1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
        end
    end

    // The filtered level follows the synchronized clock only after it has
    // differed from the current level for FILTER consecutive cycles.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s != filt_q) begin
            if (filt_cnt_q == FCW'(FILTER - 1)) begin
                filt_d = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign sample = filt_q & ~filt_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        to_cnt_d  = to_cnt_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;

        if (state_q == S_IDLE || sample) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TCW'(TIMEOUT - 1)) begin
            to_cnt_d = '0;
            state_d  = S_IDLE;
            ferr_d   = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (sample) begin
            case (state_q)
                S_IDLE: begin
                    if (!dat_s) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d   = {dat_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_d   = dat_s;
                    state_d = S_STOP;
                end
                default: begin
                    if (!dat_s) begin
                        ferr_d = 1'b1;
                    end else if (odd_parity_ok(shift_q, par_q)) begin
                        valid_d = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    // shift_q is frozen once back in IDLE, so it still holds the byte
    // while the registered strobe is high.
    assign byte_valid_o = valid_q;
    assign byte_o       = shift_q;
    assign perr_pulse_o = perr_q;
    assign ferr_pulse_o = ferr_q;

endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 keyboard receiver with a scan-code FIFO on two CPU
// I/O ports.
//   clock, reset  system clock, async active-high reset
//   ps2_clk/dat   raw PS/2 lines (inputs only)
//   address       CPU data address
//   wren, data_w  CPU write strobe and data
//   data_r        read data (FIFO head or status), 0 when not addressed
//   hit           address decodes to one of the two ports
//   irq           registered FIFO-not-empty
`timescale 1ns/1ps
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter logic [15:0] PORT_DATA  = PORT_DATA_DEF,
    parameter logic [15:0] PORT_STAT  = PORT_STAT_DEF,
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned FILTER     = 8,
    parameter int unsigned TIMEOUT    = 25000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    input  logic [15:0] address,
    input  logic        wren,
    input  logic [7:0]  data_w,
    output logic [7:0]  data_r,
    output logic        hit,
    output logic        irq
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic                  rx_valid;
    logic [7:0]            rx_byte;
    logic                  rx_perr;
    logic                  rx_ferr;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  ovf_q, ovf_d;
    logic                  irq_q;

    logic                  sel_data, sel_stat;
    logic                  empty, full;
    logic                  pop, push;
    logic [7:0]            status;
    logic                  unused_data_w;

    ps2_rx_frame #(
        .FILTER  (FILTER),
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .clk_i        (clock),
        .rst_i        (reset),
        .ps2_clk_i    (ps2_clk),
        .ps2_dat_i    (ps2_dat),
        .byte_valid_o (rx_valid),
        .byte_o       (rx_byte),
        .perr_pulse_o (rx_perr),
        .ferr_pulse_o (rx_ferr)
    );

    assign sel_data = (address == PORT_DATA);
    assign sel_stat = (address == PORT_STAT);
    assign hit      = sel_data | sel_stat;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // A pop frees the slot in the same cycle, so push-while-full is only
    // an overflow when no pop accompanies it.
    assign pop  = wren & sel_data & ~empty;
    assign push = rx_valid & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Sticky bits: write-1-to-clear, with a same-cycle set taking priority.
    always_comb begin
        perr_d = perr_q;
        ferr_d = ferr_q;
        ovf_d  = ovf_q;
        if (wren && sel_stat) begin
            if (data_w[ST_PERR]) perr_d = 1'b0;
            if (data_w[ST_FERR]) ferr_d = 1'b0;
            if (data_w[ST_OVF])  ovf_d  = 1'b0;
        end
        if (rx_perr) perr_d = 1'b1;
        if (rx_ferr) ferr_d = 1'b1;
        if (rx_valid && full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            ovf_q    <= ovf_d;
            irq_q    <= (count_d != '0);
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_byte;
        end
    end

    always_comb begin
        status          = '0;
        status[ST_NE]   = ~empty;
        status[ST_FULL] = full;
        status[ST_PERR] = perr_q;
        status[ST_FERR] = ferr_q;
        status[ST_OVF]  = ovf_q;
    end

    always_comb begin
        data_r = '0;
        if (sel_data) begin
            data_r = empty ? 8'h00 : mem_q[rd_ptr_q];
        end else if (sel_stat) begin
            data_r = status;
        end
    end

    assign irq = irq_q;

    assign unused_data_w = ^{data_w[7:5], data_w[1:0]};

endmodule

// File: tb/tb_ps2_keyboard.sv
`timescale 1ns/1ps
module tb_ps2_keyboard;

    localparam logic [15:0] A_DATA = 16'h0030;
    localparam logic [15:0] A_STAT = 16'h0031;
    localparam int TO_CYC = 2000;

    logic        clock = 1'b0;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_dat;
    logic [15:0] address;
    logic        wren;
    logic [7:0]  data_w;
    logic [7:0]  data_r;
    logic        hit;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;
    int half     = 30;
    int push_lat = 0;

    // Behavioural model: queue of received bytes plus sticky flags.
    logic [7:0] q[$];
    bit m_perr, m_ferr, m_ovf;

    typedef struct {
        logic [15:0] addr;
        logic        exp_hit;
        logic [7:0]  exp_data;
    } vec_t;

    ps2_keyboard #(.TIMEOUT(TO_CYC)) dut (
        .clock   (clock),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_dat (ps2_dat),
        .address (address),
        .wren    (wren),
        .data_w  (data_w),
        .data_r  (data_r),
        .hit     (hit),
        .irq     (irq)
    );

    always #20 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        return {3'b000, m_ovf, m_ferr, m_perr, q.size() == 8, q.size() != 0};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d, output logic h);
        address = a;
        wren    = 1'b0;
        #1;
        d = data_r;
        h = hit;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        address = a;
        data_w  = d;
        wren    = 1'b1;
        cyc(1);
        wren    = 1'b0;
        address = 16'h0000;
        if (a == A_DATA && q.size() > 0) void'(q.pop_front());
        if (a == A_STAT) begin
            if (d[2]) m_perr = 1'b0;
            if (d[3]) m_ferr = 1'b0;
            if (d[4]) m_ovf  = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        logic [7:0] d;
        logic       h;
        logic [7:0] head;
        head = (q.size() > 0) ? q[0] : 8'h00;
        rd(A_STAT, d, h);
        check({tag, "_status"}, d, exp_status());
        rd(A_DATA, d, h);
        check({tag, "_head"}, d, head);
        check({tag, "_irq"}, irq, q.size() != 0);
    endtask

    // One PS/2 bit: data set while clock high, device pulls clock low.
    // With glitch set, 1-cycle pulses are injected in both clock phases.
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_dat = b;
        if (glitch) begin
            cyc(half / 2);
            ps2_clk = 1'b0; cyc(1); ps2_clk = 1'b1;
            cyc(half - half / 2 - 1);
            ps2_clk = 1'b0;
            cyc(half / 2);
            ps2_clk = 1'b1; cyc(1); ps2_clk = 1'b0;
            cyc(half - half / 2 - 1);
        end else begin
            cyc(half);
            ps2_clk = 1'b0;
            cyc(half);
        end
        ps2_clk = 1'b1;
    endtask

    // pop_edge > 0: pop lands on that clock edge after the stop-bit fall.
    // calib: measure edges from the stop-bit fall until irq is seen.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int pop_edge, input bit calib, input bit glitch);
        logic par;
        bit   found;
        par = (~^b) ^ bad_par;
        ps2_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
        ps2_bit(par, glitch);
        ps2_dat = ~bad_stop;
        cyc(half);
        ps2_clk = 1'b0;
        if (calib) begin
            found = 1'b0;
            for (int n = 1; n < half; n++) begin
                cyc(1);
                if (irq === 1'b1 && !found) begin
                    push_lat = n;
                    found    = 1'b1;
                end
            end
            cyc(1);
            check("push_latency_found", found, 1);
        end else if (pop_edge > 0) begin
            cyc(pop_edge - 1);
            address = A_DATA;
            wren    = 1'b1;
            cyc(1);
            wren    = 1'b0;
            address = 16'h0000;
            cyc(half - pop_edge);
        end else begin
            cyc(half);
        end
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        cyc(8);
        if (pop_edge > 0 && q.size() > 0) void'(q.pop_front());
        if (bad_stop)            m_ferr = 1'b1;
        else if (bad_par)        m_perr = 1'b1;
        else if (q.size() < 8)   q.push_back(b);
        else                     m_ovf = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        q.delete();
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
        cyc(20);
    endtask

    initial begin
        vec_t       vt[8];
        logic [7:0] d;
        logic       h;

        reset   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        address = 16'h0000;
        wren    = 1'b0;
        data_w  = 8'h00;
        cyc(2);
        do_reset();

        // Reset state
        check("rst_irq", irq, 0);
        rd(16'h0000, d, h);
        check("rst_unaddr_data", d, 8'h00);
        check("rst_unaddr_hit", h, 0);
        rd(A_STAT, d, h);
        check("rst_status", d, 8'h00);

        // 1: 8'h1C at a 40 us PS/2 clock period
        half = 500;
        send_frame(8'h1C, 0, 0, 0, 1, 0);
        half = 30;
        rd(A_STAT, d, h);
        check("t1_status_const", d, 8'h01);
        check_state("t1");

        vt[0] = '{16'h0030, 1'b1, 8'h1C};
        vt[1] = '{16'h0031, 1'b1, 8'h01};
        vt[2] = '{16'h0032, 1'b0, 8'h00};
        vt[3] = '{16'h002F, 1'b0, 8'h00};
        vt[4] = '{16'h1030, 1'b0, 8'h00};
        vt[5] = '{16'h0130, 1'b0, 8'h00};
        vt[6] = '{16'hFFFF, 1'b0, 8'h00};
        vt[7] = '{16'h8031, 1'b0, 8'h00};
        for (int i = 0; i < 8; i++) begin
            rd(vt[i].addr, d, h);
            check($sformatf("decode_hit_%04h", vt[i].addr), h, vt[i].exp_hit);
            check($sformatf("decode_data_%04h", vt[i].addr), d, vt[i].exp_data);
        end

        wr(A_DATA, 8'h00);
        cyc(1);
        check_state("t1_pop");
        wr(A_DATA, 8'h00);
        cyc(1);
        check_state("t1_pop_empty");

        // 2: parity error, then write-1-to-clear
        send_frame(8'hF0, 1, 0, 0, 0, 0);
        rd(A_STAT, d, h);
        check("t2_status_const", d, 8'h04);
        check_state("t2");
        wr(A_STAT, 8'h04);
        check_state("t2_clr");

        // 3: overflow on the ninth byte
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0, 0, 0);
        rd(A_STAT, d, h);
        check("t3_status_const", d, 8'h13);
        check_state("t3_full");
        for (int i = 1; i <= 8; i++) begin
            rd(A_DATA, d, h);
            check($sformatf("t3_pop_%0d", i), d, 8'(i));
            wr(A_DATA, 8'h00);
        end
        rd(A_STAT, d, h);
        check("t3_status_after", d, 8'h10);
        wr(A_STAT, 8'h1C);
        check_state("t3_clr");

        // 5: pop on the exact push cycle while full
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 0, 0, 0, 0, 0);
        send_frame(8'h77, 0, 0, push_lat, 0, 0);
        rd(A_STAT, d, h);
        check("t5_status_const", d, 8'h03);
        check_state("t5");
        for (int i = 0; i < 8; i++) begin
            rd(A_DATA, d, h);
            check($sformatf("t5_drain_%0d", i), d, q[0]);
            wr(A_DATA, 8'h00);
        end
        check("t5_last_was_new", d, 8'h77);
        check_state("t5_empty");

        // 4: timeout mid-frame, then a good frame
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        cyc(TO_CYC + 50);
        m_ferr = 1'b1;
        rd(A_STAT, d, h);
        check("t4_status_const", d, 8'h08);
        check_state("t4_timeout");
        send_frame(8'h5A, 0, 0, 0, 0, 0);
        check_state("t4_after");
        wr(A_DATA, 8'h00);
        wr(A_STAT, 8'h08);
        check_state("t4_clr");

        // Random frames, random pops and status clears
        for (int it = 0; it < 24; it++) begin
            int kind, act;
            kind = $urandom_range(0, 9);
            send_frame(8'($urandom), kind == 0, kind == 1, 0, 0, 0);
            act = $urandom_range(0, 3);
            if (act == 0 || act == 2) wr(A_DATA, 8'($urandom));
            if (act == 1 || act == 2) wr(A_STAT, 8'($urandom));
            check_state($sformatf("rnd%0d", it));
        end
        while (q.size() > 0) wr(A_DATA, 8'h00);
        wr(A_STAT, 8'hFF);
        check_state("rnd_drained");

        // 6: glitches on a full frame, then reset mid-frame
        send_frame(8'hA7, 0, 0, 0, 0, 1);
        check_state("t6_glitch");
        ps2_bit(1'b0, 1);
        ps2_bit(1'b1, 1);
        ps2_dat = 1'b0;
        cyc(half);
        ps2_clk = 1'b0;
        cyc(5);
        reset   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        cyc(3);
        reset   = 1'b0;
        q.delete();
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
        cyc(40);
        rd(A_STAT, d, h);
        check("t6_rst_status", d, 8'h00);
        check("t6_rst_irq", irq, 0);
        send_frame(8'h3C, 0, 0, 0, 0, 0);
        check_state("t6_post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20ms;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
